// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO drain controller.
package fifo_rr_arbiter_pkg;

    localparam int unsigned GRANT_W = 3;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Round-robin search: first set request at or after ptr, modulo N_IN.
module fifo_rr_arbiter_rr_pick
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_IN = 4
) (
    input  logic [N_IN-1:0]    req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [N_IN-1:0]    onehot,
    output logic [GRANT_W-1:0] idx,
    output logic               any
);

    logic [2*N_IN-1:0]  dbl;
    logic [N_IN-1:0]    rot;
    logic [GRANT_W-1:0] ptr_mod;
    logic [GRANT_W-1:0] enc;

    // Rotate so ptr lands at bit 0, pick the lowest set bit, rotate the index back.
    always_comb begin
        ptr_mod = GRANT_W'(32'(ptr) % N_IN);
        dbl     = {req, req};
        rot     = N_IN'(dbl >> ptr_mod);
        enc     = '0;
        any     = 1'b0;
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = GRANT_W'(i);
                any = 1'b1;
            end
        end
        idx    = GRANT_W'((32'(enc) + 32'(ptr_mod)) % N_IN);
        onehot = any ? (N_IN'(1) << idx) : '0;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains N_IN first-word-fall-through FIFOs round-robin into one downstream FIFO
// and drives the full/empty thresholds shared by all of them.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 6,
    parameter int unsigned PTR_L     = 3,
    parameter int unsigned N_IN      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PTR_L-1:0]          cfg_full_th,
    input  logic [PTR_L-1:0]          cfg_empty_th,
    input  logic [N_IN-1:0]           in_empty,
    input  logic [N_IN*WORD_SIZE-1:0] in_data,
    output logic [N_IN-1:0]           in_rd,
    input  logic                      out_almost_full,
    input  logic                      out_full,
    output logic                      out_wr,
    output logic [WORD_SIZE-1:0]      out_data,
    output logic [GRANT_W-1:0]        grant_id,
    output logic [PTR_L-1:0]          full_threshold,
    output logic [PTR_L-1:0]          empty_threshold,
    output logic                      idle,
    output logic [COUNT_W-1:0]        word_count,
    output logic                      error
);

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic                 out_wr_q, out_wr_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [PTR_L-1:0]     full_th_q, full_th_d;
    logic [PTR_L-1:0]     empty_th_q, empty_th_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 error_q, error_d;

    logic [N_IN-1:0]      pick_onehot;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 pick_any;
    logic                 stall;
    logic                 pop;
    logic [WORD_SIZE-1:0] pick_data;

    fifo_rr_arbiter_rr_pick #(.N_IN(N_IN)) u_pick (
        .req    (~in_empty),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign stall = out_almost_full | out_full;

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (pick_onehot[i]) pick_data = in_data[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    // Next state, pop strobe and pipeline inputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        full_th_d  = full_th_q;
        empty_th_d = empty_th_q;
        in_rd      = '0;
        unique case (state_q)
            ST_INIT: begin
                full_th_d  = cfg_full_th;
                empty_th_d = cfg_empty_th;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                if (pick_any && !stall) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                in_rd = stall ? '0 : pick_onehot;
                if (stall)          state_d = ST_PAUSE;
                else if (!pick_any) state_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!stall) state_d = pick_any ? ST_ACTIVE : ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        pop = |in_rd;
        if (pop) ptr_d = (pick_idx == GRANT_W'(N_IN - 1)) ? '0 : pick_idx + GRANT_W'(1);

        out_wr_d   = pop;
        out_data_d = pop ? pick_data : out_data_q;
        grant_d    = pop ? pick_idx : grant_q;
        count_d    = pop ? count_q + COUNT_W'(1) : count_q;
        // A write landing while downstream is already full is lost; flag it until reset.
        error_d    = error_q | (out_wr_q & out_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            grant_q    <= '0;
            full_th_q  <= '0;
            empty_th_q <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            grant_q    <= grant_d;
            full_th_q  <= full_th_d;
            empty_th_q <= empty_th_d;
            count_q    <= count_d;
            error_q    <= error_d;
        end
    end

    assign out_wr          = out_wr_q;
    assign out_data        = out_data_q;
    assign grant_id        = grant_q;
    assign full_threshold  = full_th_q;
    assign empty_threshold = empty_th_q;
    assign idle            = (state_q == ST_IDLE);
    assign word_count      = count_q;
    assign error           = error_q;

endmodule
